spi_flash_arbiter: RTL and testbench



---
 rtl/spi_flash_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one SPI flash port between two SPI masters (0: USB-SPI bridge,
//   1: secondary flash client). Ownership is granted per transaction, with
//   round-robin tie-break, an optional hold watchdog, and a chip-select-high
//   guard interval between owners.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   req[1:0]      ownership requests, bit n = requester n
//   gnt[1:0]      registered one-hot-or-zero grant
//   cs_b_in[1:0]  per-requester chip select (active-low)
//   sck_in[1:0]   per-requester SPI clock
//   mosi_in[1:0]  per-requester MOSI
//   miso_out[1:0] flash MISO fanned out to both requesters
//   spi_cs        flash chip select (active-low)
//   spi_sck       flash SPI clock
//   spi_mosi      flash MOSI
//   spi_miso      flash MISO
//   busy          high whenever not IDLE
//   hold_timeout  one-cycle pulse when the watchdog revokes a grant
module spi_flash_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int MAX_HOLD     = 0,
  parameter int HOLD_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] cs_b_in,
  input  logic [1:0] sck_in,
  input  logic [1:0] mosi_in,
  output logic [1:0] miso_out,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       busy,
  output logic       hold_timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

  // Guard counter must hold GUARD_CYCLES; keep at least one bit for 0/1.
  localparam int                GUARD_W    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
  localparam bit                WD_EN      = (MAX_HOLD > 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = WD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_t             state_reg;
  logic [1:0]         gnt_reg;
  logic               busy_reg;
  logic               hold_timeout_reg;
  logic               last_served_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic [1:0]         lockout_reg;
  logic [GUARD_W-1:0] guard_cnt_reg;

  logic       own_idx;
  logic [1:0] own_onehot;
  logic       own_req;
  logic [1:0] eligible;
  logic       pick;
  logic       wd_fire;
  logic [1:0] lockout_clr;

  always_comb begin
    own_idx     = (state_reg == OWN1);
    own_onehot  = own_idx ? 2'b10 : 2'b01;
    own_req     = req[own_idx];
    eligible    = req & ~lockout_reg;
    // Tie goes to whoever was not served last; otherwise the lone requester.
    pick        = (eligible == 2'b11) ? ~last_served_reg : eligible[1];
    // A simultaneous req drop wins over expiry: own_req must still be high.
    wd_fire     = WD_EN && ((state_reg == OWN0) || (state_reg == OWN1)) &&
                  own_req && (hold_cnt_reg == HOLD_LAST);
    // Lockout is cleared in any cycle the locked-out requester lets go.
    lockout_clr = lockout_reg & req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      gnt_reg          <= 2'b00;
      busy_reg         <= 1'b0;
      hold_timeout_reg <= 1'b0;
      last_served_reg  <= 1'b1;
      hold_cnt_reg     <= '0;
      lockout_reg      <= 2'b00;
      guard_cnt_reg    <= '0;
    end else begin
      hold_timeout_reg <= 1'b0;
      lockout_reg      <= lockout_clr;
      case (state_reg)
        IDLE: begin
          if (eligible != 2'b00) begin
            state_reg       <= pick ? OWN1 : OWN0;
            gnt_reg         <= pick ? 2'b10 : 2'b01;
            last_served_reg <= pick;
            hold_cnt_reg    <= '0;
            busy_reg        <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!own_req || wd_fire) begin
            state_reg     <= GUARD;
            gnt_reg       <= 2'b00;
            guard_cnt_reg <= GUARD_LOAD;
            if (wd_fire) begin
              hold_timeout_reg <= 1'b1;
              lockout_reg      <= lockout_clr | own_onehot;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        GUARD: begin
          // Leaving at count 1 gives exactly GUARD_CYCLES cycles here;
          // a load of 0 still costs one cycle.
          if (guard_cnt_reg <= GUARD_W'(1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            guard_cnt_reg <= guard_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Pins follow the registered owner; IDLE and GUARD force the bus idle
  // even if the previous owner still holds its chip select low.
  always_comb begin
    spi_cs   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    case (state_reg)
      OWN0: begin
        spi_cs   = cs_b_in[0];
        spi_sck  = sck_in[0];
        spi_mosi = mosi_in[0];
      end
      OWN1: begin
        spi_cs   = cs_b_in[1];
        spi_sck  = sck_in[1];
        spi_mosi = mosi_in[1];
      end
      default: begin
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_miso
      assign miso_out[gi] = spi_miso;
    end
  endgenerate

  assign gnt          = gnt_reg;
  assign busy         = busy_reg;
  assign hold_timeout = hold_timeout_reg;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Testbench for spi_flash_arbiter.
//   dut_a: GUARD_CYCLES=4, MAX_HOLD=16 (main behaviour + watchdog)
//   dut_b: GUARD_CYCLES=0, MAX_HOLD=0  (minimum guard spacing)
// Both share the stimulus; each row pushes its expected outputs to a
// scoreboard queue and the entry is popped and compared after the edge.
module tb_spi_flash_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, cs_b_in, sck_in, mosi_in;
  logic       spi_miso;

  logic [1:0] a_gnt, a_miso;
  logic       a_cs, a_sck, a_mosi, a_busy, a_to;
  logic [1:0] b_gnt, b_miso;
  logic       b_cs, b_sck, b_mosi, b_busy, b_to;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit sel = 1'b0;  // 0: check dut_a, 1: check dut_b

  typedef struct {
    string      tag;
    logic [1:0] gnt;
    logic       cs, sck, mosi, busy, to;
    logic [1:0] miso;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  spi_flash_arbiter #(.GUARD_CYCLES(4), .MAX_HOLD(16), .HOLD_W(24)) dut_a (
    .clk(clk), .reset(reset), .req(req), .gnt(a_gnt),
    .cs_b_in(cs_b_in), .sck_in(sck_in), .mosi_in(mosi_in), .miso_out(a_miso),
    .spi_cs(a_cs), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_miso(spi_miso),
    .busy(a_busy), .hold_timeout(a_to)
  );

  spi_flash_arbiter #(.GUARD_CYCLES(0), .MAX_HOLD(0), .HOLD_W(8)) dut_b (
    .clk(clk), .reset(reset), .req(req), .gnt(b_gnt),
    .cs_b_in(cs_b_in), .sck_in(sck_in), .mosi_in(mosi_in), .miso_out(b_miso),
    .spi_cs(b_cs), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(spi_miso),
    .busy(b_busy), .hold_timeout(b_to)
  );

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected pins follow the expected owner; no owner means idle pins.
  function automatic exp_t make_exp(input string tag, input logic [1:0] eg,
                                    input logic eb, input logic et);
    exp_t e;
    e.tag  = tag;
    e.gnt  = eg;
    e.busy = eb;
    e.to   = et;
    e.cs   = 1'b1;
    e.sck  = 1'b0;
    e.mosi = 1'b0;
    if (eg == 2'b01) begin
      e.cs = cs_b_in[0]; e.sck = sck_in[0]; e.mosi = mosi_in[0];
    end else if (eg == 2'b10) begin
      e.cs = cs_b_in[1]; e.sck = sck_in[1]; e.mosi = mosi_in[1];
    end
    e.miso = {spi_miso, spi_miso};
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      err_cnt++;
      $display("FAIL scoreboard: got empty queue want an entry");
      return;
    end
    e = sb.pop_front();
    chk_val({e.tag, "/gnt"},  8'(sel ? b_gnt  : a_gnt),  8'(e.gnt));
    chk_val({e.tag, "/cs"},   8'(sel ? b_cs   : a_cs),   8'(e.cs));
    chk_val({e.tag, "/sck"},  8'(sel ? b_sck  : a_sck),  8'(e.sck));
    chk_val({e.tag, "/mosi"}, 8'(sel ? b_mosi : a_mosi), 8'(e.mosi));
    chk_val({e.tag, "/busy"}, 8'(sel ? b_busy : a_busy), 8'(e.busy));
    chk_val({e.tag, "/to"},   8'(sel ? b_to   : a_to),   8'(e.to));
    chk_val({e.tag, "/miso"}, 8'(sel ? b_miso : a_miso), 8'(e.miso));
  endtask

  // One clocked row: drive inputs, push the expected post-edge outputs,
  // clock, then compare.
  task automatic cyc(input string tag, input logic [1:0] r, input logic [1:0] cb,
                     input logic [1:0] sk, input logic [1:0] mo,
                     input logic [1:0] eg, input logic eb, input logic et);
    req      = r;
    cs_b_in  = cb;
    sck_in   = sk;
    mosi_in  = mo;
    spi_miso = 1'($urandom_range(0, 1));
    sb.push_back(make_exp(tag, eg, eb, et));
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Asserts reset mid-cycle and checks both DUTs go idle without a clock edge.
  task automatic reset_chk(input string tag);
    bit keep_sel;
    keep_sel = sel;
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      sb.push_back(make_exp(tag, 2'b00, 1'b0, 1'b0));
      compare_head();
    end
    sel = keep_sel;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Rows for the remaining 3 GUARD cycles (dut_a) followed by one IDLE cycle.
  task automatic drain(input string tag, input logic [1:0] r);
    for (int i = 0; i < 3; i++) cyc({tag, "_guard"}, r, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc({tag, "_idle"}, r, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: got no finish want finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    reset    = 1'b1;
    req      = 2'b00;
    cs_b_in  = 2'b11;
    sck_in   = 2'b00;
    mosi_in  = 2'b00;
    spi_miso = 1'b1;
    @(posedge clk);
    #1;
    reset_chk("rst_init");

    // Single requester, pins follow owner 0, MISO fan-out
    cyc("s1_gnt",    2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s1_follow", 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
    cyc("s1_rel",    2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drain("s1", 2'b00);

    // Tie after reset goes to 0, guard spacing, no preemption, round-robin
    reset_chk("rst_s2");
    cyc("s2_tie",   2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s2_hold",  2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s2_rel0",  2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("s2_guard", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc("s2_idle",  2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
    cyc("s2_gnt1",  2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0);
    cyc("s2_nopre", 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
    cyc("s2_rel1",  2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("s2_guard", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc("s2_idle2", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("s2_rr",    2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s2_rel",   2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drain("s2", 2'b00);

    // Owner drops req with cs still low: pins forced idle at once
    cyc("s3_own",  2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s3_drop", 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("s3_guard", 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc("s3_idle", 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // Watchdog: 16-cycle hold, pulse, lockout until req[0] drops
    cyc("s4_gnt", 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cyc("s4_hold", 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s4_timeout", 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    drain("s4", 2'b01);
    for (int i = 0; i < 2; i++) cyc("s4_locked", 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("s4_other", 2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
    cyc("s4_clr",   2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
    cyc("s4_rel1",  2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drain("s4b", 2'b01);
    cyc("s4_regnt", 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    // Drop req on the very cycle the watchdog would expire: normal release
    for (int i = 0; i < 15; i++) cyc("s4_hold2", 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s4_simul", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drain("s4c", 2'b00);
    cyc("s4_nolock", 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s4_rel",    2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drain("s4d", 2'b00);

    // Asynchronous reset mid-transfer in OWN1
    cyc("s5_own1", 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0);
    reset_chk("s5_rst");
    cyc("s5_tie",  2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);

    // GUARD_CYCLES=0: exactly two cs-high cycles between owners
    reset_chk("rst_s6");
    sel = 1'b1;
    cyc("s6_own0", 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cyc("s6_rel",  2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    cyc("s6_idle", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc("s6_own1", 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
